// File: rtl/dc_port_if.sv
// dc_port_if: bundles the store/load-buffer request/response signals and the
// byte-wide synchronous RAM signals of dc_port.
//   master : requester/RAM side (drives iSLB_*, iRAM_dt; observes o*)
//   slave  : dc_port side
// iSLB_len encoding: 2'd0 = one byte, 2'd1 = two bytes, 2'd2 = four bytes,
// 2'd3 is illegal and handled as four bytes.
interface dc_port_if #(
  parameter int unsigned NickW = 4
);
  // Store/load buffer request
  logic             iSLB_en;
  logic             iSLB_ls;    // 0 = load, 1 = store
  logic [NickW-1:0] iSLB_nick;
  logic [1:0]       iSLB_len;
  logic [31:0]      iSLB_addr;
  logic [31:0]      iSLB_dt;
  // Store/load buffer response
  logic             oSLB_rdy;
  logic             oSLB_done;
  logic [NickW-1:0] oSLB_nick;
  logic [31:0]      oSLB_dt;
  // Byte RAM
  logic [31:0]      oRAM_addr;
  logic             oRAM_wr;
  logic [7:0]       oRAM_dt;
  logic [7:0]       iRAM_dt;

  modport master (
    output iSLB_en, iSLB_ls, iSLB_nick, iSLB_len, iSLB_addr, iSLB_dt, iRAM_dt,
    input  oSLB_rdy, oSLB_done, oSLB_nick, oSLB_dt, oRAM_addr, oRAM_wr, oRAM_dt
  );

  modport slave (
    input  iSLB_en, iSLB_ls, iSLB_nick, iSLB_len, iSLB_addr, iSLB_dt, iRAM_dt,
    output oSLB_rdy, oSLB_done, oSLB_nick, oSLB_dt, oRAM_addr, oRAM_wr, oRAM_dt
  );
endinterface

// File: rtl/dc_port.sv
// dc_port: single-request data-cache port. Serialises 1/2/4-byte loads and
// stores from the store/load buffer onto a byte-wide RAM with one-cycle read
// latency. Addresses need no alignment and wrap at 32 bits.
// Ports:
//   clk  - clock, all state changes on posedge
//   rst  - asynchronous active-low reset
//   rdy  - global enable; 0 stalls the port (registers hold, RAM write masked)
//   clr  - synchronous flush; aborts loads, never aborts a committed store,
//          blocks acceptance while idle
//   bus  - dc_port_if slave modport (request, response and RAM signals)
// Timing (edge 0 = accept edge):
//   store : byte k written in the cycle after edge k, idle after edge len
//   load  : address addr+k after edge k, byte k captured at edge k+2,
//           one-cycle oSLB_done after edge len+1
module dc_port #(
  parameter int unsigned NickW = 4
) (
  input logic      clk,
  input logic      rst,
  input logic      rdy,
  input logic      clr,
  dc_port_if.slave bus
);

  localparam logic [1:0] LenOne = 2'd0;
  localparam logic [1:0] LenTwo = 2'd1;

  typedef enum logic [1:0] {StIdle, StLoad, StStore} state_e;

  // Decoded byte count; anything other than one/two is four bytes.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LenOne:  len_bytes = 3'd1;
      LenTwo:  len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

  state_e           r_state;
  logic [2:0]       r_cnt;      // store: byte driven; load: edges since (re)start
  logic [2:0]       r_len;
  logic [NickW-1:0] r_nick;
  logic [31:0]      r_addr;
  logic [31:0]      r_dt;
  logic [31:0]      r_res;
  logic             r_stall;    // a load saw rdy=0 and must refetch from byte 0
  logic             r_done;
  logic [NickW-1:0] r_nick_o;
  logic [31:0]      r_dt_o;
  logic [31:0]      r_ram_addr;
  logic             r_ram_wr;
  logic [7:0]       r_ram_dt;

  logic             w_slb_rdy;
  logic             w_accept;
  logic [2:0]       w_cnt_nx;
  logic [1:0]       w_idx;
  logic [31:0]      w_res_cap;
  logic [7:0]       w_st_byte;

  assign w_slb_rdy = (r_state == StIdle) && rdy && !clr;
  assign w_accept  = bus.iSLB_en && w_slb_rdy;
  assign w_cnt_nx  = r_cnt + 3'd1;
  // Byte arriving now was addressed two edges ago, i.e. index r_cnt-1.
  assign w_idx     = r_cnt[1:0] - 2'd1;
  assign w_res_cap = r_res | (32'(bus.iRAM_dt) << {w_idx, 3'b000});
  assign w_st_byte = 8'(r_dt >> {w_cnt_nx[1:0], 3'b000});

  assign bus.oSLB_rdy  = w_slb_rdy;
  assign bus.oSLB_done = r_done;
  assign bus.oSLB_nick = r_nick_o;
  assign bus.oSLB_dt   = r_dt_o;
  assign bus.oRAM_addr = r_ram_addr;
  // A stalled store keeps its byte registered but must not write it.
  assign bus.oRAM_wr   = r_ram_wr & rdy;
  assign bus.oRAM_dt   = r_ram_dt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_nick     <= '0;
      r_addr     <= 32'd0;
      r_dt       <= 32'd0;
      r_res      <= 32'd0;
      r_stall    <= 1'b0;
      r_done     <= 1'b0;
      r_nick_o   <= '0;
      r_dt_o     <= 32'd0;
      r_ram_addr <= 32'd0;
      r_ram_wr   <= 1'b0;
      r_ram_dt   <= 8'd0;
    end else begin
      // Completion is a pulse, so it never holds across a stall.
      r_done <= 1'b0;
      if (rdy) begin
        unique case (r_state)
          StIdle: begin
            if (w_accept) begin
              r_nick     <= bus.iSLB_nick;
              r_len      <= len_bytes(bus.iSLB_len);
              r_addr     <= bus.iSLB_addr;
              r_dt       <= bus.iSLB_dt;
              r_cnt      <= 3'd0;
              r_res      <= 32'd0;
              r_stall    <= 1'b0;
              r_ram_addr <= bus.iSLB_addr;
              if (bus.iSLB_ls) begin
                r_state  <= StStore;
                r_ram_wr <= 1'b1;
                r_ram_dt <= bus.iSLB_dt[7:0];
              end else begin
                r_state  <= StLoad;
                r_ram_wr <= 1'b0;
              end
            end
          end

          // clr is deliberately ignored: a store is committed once accepted.
          StStore: begin
            if (w_cnt_nx == r_len) begin
              r_state  <= StIdle;
              r_cnt    <= 3'd0;
              r_ram_wr <= 1'b0;
            end else begin
              r_cnt      <= w_cnt_nx;
              r_ram_addr <= r_addr + 32'(w_cnt_nx);
              r_ram_dt   <= w_st_byte;
            end
          end

          StLoad: begin
            if (clr) begin
              r_state <= StIdle;
              r_cnt   <= 3'd0;
              r_stall <= 1'b0;
            end else if (r_stall) begin
              // Bytes fetched before the stall are not trusted; start over.
              r_stall    <= 1'b0;
              r_cnt      <= 3'd0;
              r_res      <= 32'd0;
              r_ram_addr <= r_addr;
            end else begin
              if (r_cnt != 3'd0) begin
                r_res <= w_res_cap;
              end
              if (r_cnt == r_len) begin
                r_state  <= StIdle;
                r_cnt    <= 3'd0;
                r_done   <= 1'b1;
                r_nick_o <= r_nick;
                r_dt_o   <= w_res_cap;
              end else begin
                r_cnt <= w_cnt_nx;
                if (w_cnt_nx < r_len) begin
                  r_ram_addr <= r_addr + 32'(w_cnt_nx);
                end
              end
            end
          end

          default: r_state <= StIdle;
        endcase
      end else if (r_state == StLoad) begin
        r_stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dc_port.sv
module tb_dc_port;

  localparam logic [1:0] LenOne  = 2'd0;
  localparam logic [1:0] LenTwo  = 2'd1;
  localparam logic [1:0] LenFour = 2'd2;
  localparam logic [1:0] LenBad  = 2'd3;

  logic clk;
  logic rst;
  logic rdy;
  logic clr;

  int n_cmp;
  int n_err;

  // Read-only RAM image for loads: four bytes starting at ld_base.
  logic [31:0] ld_base;
  logic [31:0] ld_word;
  logic [7:0]  ram_q;

  dc_port_if #(.NickW(4)) bus ();

  dc_port #(.NickW(4)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd_fn(input logic [31:0] a);
    logic [31:0] off;
    off = a - ld_base;
    if (off < 32'd4) rd_fn = 8'(ld_word >> {off[1:0], 3'b000});
    else rd_fn = 8'hEE;
  endfunction

  always @(posedge clk) ram_q <= rd_fn(bus.oRAM_addr);
  assign bus.iRAM_dt = ram_q;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output logic wr_seen);
    cyc = 0;
    wr_seen = 1'b0;
    while (cyc < max_cyc) begin
      tick();
      cyc++;
      wr_seen = wr_seen | bus.oRAM_wr;
      if (bus.oSLB_done) break;
    end
  endtask

  task automatic do_load(input string tag, input logic [3:0] nick, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] exp_dt,
                         input int exp_cyc);
    int   cyc;
    logic wr_seen;
    bus.iSLB_en   = 1'b1;
    bus.iSLB_ls   = 1'b0;
    bus.iSLB_nick = nick;
    bus.iSLB_len  = len;
    bus.iSLB_addr = addr;
    bus.iSLB_dt   = 32'hDEADBEEF;
    check_val({tag, "_rdy_pre"}, 32'(bus.oSLB_rdy), 32'd1);
    tick();
    bus.iSLB_en = 1'b0;
    check_val({tag, "_addr0"}, bus.oRAM_addr, addr);
    check_val({tag, "_busy"}, 32'(bus.oSLB_rdy), 32'd0);
    wait_done(12, cyc, wr_seen);
    check_val({tag, "_done"}, 32'(bus.oSLB_done), 32'd1);
    check_val({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    check_val({tag, "_dt"}, bus.oSLB_dt, exp_dt);
    check_val({tag, "_nick"}, 32'(bus.oSLB_nick), 32'(nick));
    check_val({tag, "_nowr"}, 32'(wr_seen), 32'd0);
    check_val({tag, "_rdy_post"}, 32'(bus.oSLB_rdy), 32'd1);
    tick();
    check_val({tag, "_pulse"}, 32'(bus.oSLB_done), 32'd0);
  endtask

  initial begin
    int   cyc;
    logic wr_seen;
    logic seen;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    rdy = 1'b1;
    clr = 1'b0;
    bus.iSLB_en   = 1'b0;
    bus.iSLB_ls   = 1'b0;
    bus.iSLB_nick = 4'h0;
    bus.iSLB_len  = LenOne;
    bus.iSLB_addr = 32'd0;
    bus.iSLB_dt   = 32'd0;
    ld_base = 32'h0;
    ld_word = 32'h0;

    // Reset state
    #12;
    check_val("rst_done", 32'(bus.oSLB_done), 32'd0);
    check_val("rst_nick", 32'(bus.oSLB_nick), 32'd0);
    check_val("rst_dt", bus.oSLB_dt, 32'd0);
    check_val("rst_raddr", bus.oRAM_addr, 32'd0);
    check_val("rst_wr", 32'(bus.oRAM_wr), 32'd0);
    check_val("rst_rdt", 32'(bus.oRAM_dt), 32'd0);
    check_val("rst_idle", 32'(bus.oSLB_rdy), 32'd1);
    rst = 1'b1;
    tick();

    // Four-byte load
    ld_base = 32'h100;
    ld_word = 32'h44332211;
    do_load("ld4", 4'h5, LenFour, 32'h100, 32'h44332211, 5);
    // Two-byte unaligned load, upper bytes zero
    do_load("ld2", 4'hA, LenTwo, 32'h101, 32'h00003322, 3);
    // Illegal length behaves as four bytes
    do_load("ldbad", 4'h3, LenBad, 32'h100, 32'h44332211, 5);

    // One-byte load at top of address space, and a wrapping two-byte load
    ld_base = 32'hFFFFFFFF;
    ld_word = 32'h00007F80;
    do_load("ld1top", 4'h6, LenOne, 32'hFFFFFFFF, 32'h00000080, 2);
    do_load("ldwrap", 4'h9, LenTwo, 32'hFFFFFFFF, 32'h00007F80, 3);

    // Two-byte store across 0x1FF/0x200
    bus.iSLB_en   = 1'b1;
    bus.iSLB_ls   = 1'b1;
    bus.iSLB_nick = 4'h2;
    bus.iSLB_len  = LenTwo;
    bus.iSLB_addr = 32'h1FF;
    bus.iSLB_dt   = 32'hAABBCCDD;
    tick();
    bus.iSLB_en = 1'b0;
    check_val("st2_wr0", 32'(bus.oRAM_wr), 32'd1);
    check_val("st2_a0", bus.oRAM_addr, 32'h1FF);
    check_val("st2_d0", 32'(bus.oRAM_dt), 32'hDD);
    tick();
    check_val("st2_wr1", 32'(bus.oRAM_wr), 32'd1);
    check_val("st2_a1", bus.oRAM_addr, 32'h200);
    check_val("st2_d1", 32'(bus.oRAM_dt), 32'hCC);
    check_val("st2_nodone", 32'(bus.oSLB_done), 32'd0);
    tick();
    check_val("st2_wr_end", 32'(bus.oRAM_wr), 32'd0);
    check_val("st2_rdy", 32'(bus.oSLB_rdy), 32'd1);
    check_val("st2_nodone2", 32'(bus.oSLB_done), 32'd0);

    // clr while idle blocks acceptance
    bus.iSLB_en   = 1'b1;
    bus.iSLB_ls   = 1'b1;
    bus.iSLB_len  = LenOne;
    bus.iSLB_addr = 32'h300;
    clr = 1'b1;
    #1;
    check_val("clridle_rdy", 32'(bus.oSLB_rdy), 32'd0);
    tick();
    check_val("clridle_wr", 32'(bus.oRAM_wr), 32'd0);
    bus.iSLB_en = 1'b0;
    clr = 1'b0;
    #1;
    check_val("clridle_idle", 32'(bus.oSLB_rdy), 32'd1);

    // clr mid-load aborts without done
    ld_base = 32'h100;
    ld_word = 32'h44332211;
    bus.iSLB_en   = 1'b1;
    bus.iSLB_ls   = 1'b0;
    bus.iSLB_nick = 4'hC;
    bus.iSLB_len  = LenFour;
    bus.iSLB_addr = 32'h100;
    tick();
    bus.iSLB_en = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    check_val("clrld_done", 32'(bus.oSLB_done), 32'd0);
    clr = 1'b0;
    #1;
    check_val("clrld_idle", 32'(bus.oSLB_rdy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | bus.oSLB_done;
    end
    check_val("clrld_nodone", 32'(seen), 32'd0);

    // clr mid-store does not abort
    bus.iSLB_en   = 1'b1;
    bus.iSLB_ls   = 1'b1;
    bus.iSLB_len  = LenFour;
    bus.iSLB_addr = 32'h10;
    bus.iSLB_dt   = 32'h01020304;
    tick();
    bus.iSLB_en = 1'b0;
    clr = 1'b1;
    check_val("clrst_a0", bus.oRAM_addr, 32'h10);
    check_val("clrst_d0", 32'(bus.oRAM_dt), 32'h04);
    for (int k = 1; k < 4; k++) begin
      tick();
      check_val("clrst_wr", 32'(bus.oRAM_wr), 32'd1);
      check_val("clrst_a", bus.oRAM_addr, 32'h10 + 32'(k));
      check_val("clrst_d", 32'(bus.oRAM_dt), 32'(4 - k));
    end
    tick();
    check_val("clrst_end", 32'(bus.oRAM_wr), 32'd0);
    clr = 1'b0;
    #1;
    check_val("clrst_idle", 32'(bus.oSLB_rdy), 32'd1);

    // rdy dropped three cycles mid-load: refetch from byte 0
    bus.iSLB_en   = 1'b1;
    bus.iSLB_ls   = 1'b0;
    bus.iSLB_nick = 4'h7;
    bus.iSLB_len  = LenFour;
    bus.iSLB_addr = 32'h100;
    tick();
    bus.iSLB_en = 1'b0;
    tick();
    tick();
    rdy = 1'b0;
    #1;
    check_val("stall_wr", 32'(bus.oRAM_wr), 32'd0);
    check_val("stall_busy", 32'(bus.oSLB_rdy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | bus.oRAM_wr | bus.oSLB_done;
    end
    rdy = 1'b1;
    wait_done(15, cyc, wr_seen);
    check_val("stall_quiet", 32'(seen), 32'd0);
    check_val("stall_done", 32'(bus.oSLB_done), 32'd1);
    check_val("stall_lat", 32'(cyc), 32'd6);
    check_val("stall_dt", bus.oSLB_dt, 32'h44332211);
    check_val("stall_nick", 32'(bus.oSLB_nick), 32'h7);
    check_val("stall_nowr", 32'(wr_seen), 32'd0);
    tick();

    // rdy dropped mid-store: held byte resumes
    bus.iSLB_en   = 1'b1;
    bus.iSLB_ls   = 1'b1;
    bus.iSLB_len  = LenTwo;
    bus.iSLB_addr = 32'h40;
    bus.iSLB_dt   = 32'h77665566;
    tick();
    bus.iSLB_en = 1'b0;
    rdy = 1'b0;
    #1;
    check_val("ststall_wr0", 32'(bus.oRAM_wr), 32'd0);
    tick();
    check_val("ststall_wr1", 32'(bus.oRAM_wr), 32'd0);
    check_val("ststall_a", bus.oRAM_addr, 32'h40);
    rdy = 1'b1;
    #1;
    check_val("ststall_res_wr", 32'(bus.oRAM_wr), 32'd1);
    check_val("ststall_res_d", 32'(bus.oRAM_dt), 32'h66);
    tick();
    check_val("ststall_b1_a", bus.oRAM_addr, 32'h41);
    check_val("ststall_b1_d", 32'(bus.oRAM_dt), 32'h55);
    tick();
    check_val("ststall_end", 32'(bus.oRAM_wr), 32'd0);

    // Asynchronous reset mid-store
    bus.iSLB_en   = 1'b1;
    bus.iSLB_ls   = 1'b1;
    bus.iSLB_len  = LenFour;
    bus.iSLB_addr = 32'h80;
    bus.iSLB_dt   = 32'h11223344;
    tick();
    bus.iSLB_en = 1'b0;
    tick();
    check_val("rstst_pre", 32'(bus.oRAM_wr), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("rstst_wr", 32'(bus.oRAM_wr), 32'd0);
    check_val("rstst_addr", bus.oRAM_addr, 32'd0);
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | bus.oRAM_wr | bus.oSLB_done;
    end
    check_val("rstst_quiet", 32'(seen), 32'd0);
    check_val("rstst_idle", 32'(bus.oSLB_rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dc_port.md
DC_PORT -- requirements
Module: dc_port

Interface
REQ-001 clk  in  1  system clock; all state changes on posedge.
REQ-002 rst  in  1  reset, asynchronous, active-low (rst=0 resets immediately).
REQ-003 rdy  in  1  global enable; 0 = stall.
REQ-004 clr  in  1  synchronous pipeline flush.
REQ-005 iSLB_en  in  1  request valid from store/load buffer.
REQ-006 iSLB_ls  in  1  0 = Load, 1 = Store (`Load/`Store).
REQ-007 iSLB_nick  in  `NickBus  request tag.
REQ-008 iSLB_len  in  `LenBus  byte count, `One/`Two/`Four only.
REQ-009 iSLB_addr  in  `AddrBus  byte address; no alignment required.
REQ-010 iSLB_dt  in  `DataBus  store data, little-endian; ignored for loads.
REQ-011 oSLB_rdy  out  1  port idle, accepts a request this cycle.
REQ-012 oSLB_done  out  1  one-cycle load-complete pulse.
REQ-013 oSLB_nick  out  `NickBus  tag of the completed load.
REQ-014 oSLB_dt  out  `DataBus  loaded bytes, zero-extended (sign extension is not done here).
REQ-015 oRAM_addr  out  32  RAM byte address.
REQ-016 oRAM_wr  out  1  RAM write strobe.
REQ-017 oRAM_dt  out  8  RAM write byte.
REQ-018 iRAM_dt  in  8  RAM read byte, valid the cycle after the address is sampled (one-cycle synchronous RAM).

Function
REQ-019 States SHALL be IDLE, LOAD, STORE; oSLB_rdy SHALL be 1 iff state==IDLE && rdy && !clr.
REQ-020 Accept SHALL occur at the edge where iSLB_en && oSLB_rdy; the block latches ls, nick, len, addr, dt and clears byte counter cnt and result register.
REQ-021 STORE: byte k (iSLB_dt[8k+7:8k]) SHALL be driven on oRAM_dt with oRAM_wr=1 and oRAM_addr=addr+k in the cycle after edge k (k=0..len-1); after edge len, state SHALL be IDLE and oRAM_wr 0; stores SHALL NOT pulse oSLB_done.
REQ-022 LOAD: oRAM_addr SHALL equal addr+k in the cycle after edge k (k=0..len-1), with oRAM_wr=0; iRAM_dt SHALL be captured into result bits [8k+7:8k] at edge k+2.
REQ-023 At edge len+1 of a LOAD, state SHALL return to IDLE and oSLB_done=1, oSLB_nick=latched tag, oSLB_dt=result for exactly one cycle.
REQ-024 Address arithmetic SHALL be 32-bit, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-025 Result bits above 8*len SHALL be 0.
REQ-026 rdy=0: all registers SHALL hold, and oRAM_wr SHALL be forced 0 combinationally; a STORE resumes at its current byte; a LOAD SHALL restart from byte 0 of the same request on the first rdy=1 edge, discarding partial result.
REQ-027 clr=1 during LOAD SHALL abort: IDLE next edge, no oSLB_done; clr=1 during STORE SHALL NOT abort (committed store completes); clr in IDLE SHALL block acceptance that cycle.
REQ-028 iSLB_en while not ready SHALL be ignored; requester holds it.
REQ-029 Only one request in flight; back-to-back accepts SHALL be separated by at least one IDLE cycle.
REQ-030 An illegal iSLB_len value SHALL be treated as `Four.

Reset
REQ-031 rst=0 SHALL force state=IDLE, cnt=0, oSLB_done=0, oSLB_nick=0, oSLB_dt=0, oRAM_addr=0, oRAM_wr=0, oRAM_dt=0, result=0, asynchronously and mid-operation; an interrupted access produces no done and no further writes.

Verification
REQ-032 Load len=`Four, addr 0x100, RAM bytes 11,22,33,44 -> oSLB_done at 5th cycle after accept, oSLB_dt=0x44332211, tag echoed.
REQ-033 Store len=`Two, addr 0x1FF, dt 0xAABBCCDD -> writes 0xDD@0x1FF and 0xCC@0x200 on consecutive cycles, no done, rdy back after 2 cycles.
REQ-034 Load len=`One, addr 0xFFFFFFFF, byte 0x80 -> oRAM_addr 0xFFFFFFFF, oSLB_dt=0x00000080.
REQ-035 clr asserted mid-LOAD -> no done, IDLE next cycle; clr asserted mid-STORE -> all bytes still written.
REQ-036 rdy dropped 3 cycles mid-LOAD -> oRAM_wr stays 0, load refetches from byte 0, correct data returned.
REQ-037 rst low mid-STORE -> oRAM_wr=0 immediately (before next clk), IDLE after release.
